// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM DAC output stage.
//   SAMPLE_W   : sample and counter width
//   PERIOD_LEN : clocks per PWM period (counter runs 0..CNT_MAX)
//   state_e    : stage control states
package pwm_dac_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int PERIOD_LEN = 255;
    localparam int CNT_MAX    = PERIOD_LEN - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_dac_stage_if.sv
// Sample handshake between the waveform generator and the PWM DAC stage.
//   sample_in    : unsigned sample, 0 = 0 % duty, 255 = 100 % duty
//   sample_valid : sample_in is valid this cycle
//   sample_ready : stage can take a sample (accept on valid && ready)
//   amplitude    : 4-bit gain, present only when PWM_AMPLITUDE_EN is defined
// Modports: master = sample source, slave = PWM DAC stage.
interface pwm_dac_stage_if;
    import pwm_dac_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;

`ifdef PWM_AMPLITUDE_EN
    logic [3:0]          amplitude;

    modport master (output sample_in, output sample_valid, output amplitude,
                    input  sample_ready);
    modport slave  (input  sample_in, input  sample_valid, input  amplitude,
                    output sample_ready);
`else
    modport master (output sample_in, output sample_valid,
                    input  sample_ready);
    modport slave  (input  sample_in, input  sample_valid,
                    output sample_ready);
`endif

endinterface

// File: rtl/pwm_period_counter.sv
// PWM period counter, 0..CNT_MAX with wrap back to 0.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : force the counter to 0 at the next edge (wins over run)
//   run        : advance by one at the next edge; neither input = hold
//   cnt_next   : value the counter takes at the next edge
//   wrap       : counter currently at CNT_MAX (last cycle of a period)
module pwm_period_counter
    import pwm_dac_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    output logic [SAMPLE_W-1:0] cnt_next,
    output logic                wrap
);

    localparam logic [SAMPLE_W-1:0] CNT_LAST = SAMPLE_W'(CNT_MAX);

    logic [SAMPLE_W-1:0] cnt_d;
    logic [SAMPLE_W-1:0] cnt_q;

    assign wrap     = (cnt_q == CNT_LAST);
    assign cnt_next = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = wrap ? '0 : cnt_q + SAMPLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_dac_stage.sv
// PWM DAC output stage. Buffers one sample ahead of the sample being
// rendered and renders each sample as the duty cycle of one 255-clock
// PWM period; pwm_out drives an external RC filter.
//   clk, reset   : clock and asynchronous active-high reset
//   enable       : run request, sampled every cycle
//   s_if         : sample handshake (slave side)
//   pwm_out      : registered PWM output
//   period_start : pulse in the first cycle of each rendered period
//   underrun     : pulse when a period starts with no new sample buffered
//   busy         : high while rendering (RUN or STOP)
// Optional feature macro: PWM_AMPLITUDE_EN adds a 4-bit amplitude scaler
// applied to samples as they are accepted.
module pwm_dac_stage
    import pwm_dac_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    pwm_dac_stage_if.slave  s_if,
    output logic            pwm_out,
    output logic            period_start,
    output logic            underrun,
    output logic            busy
);

    state_e              state_d, state_q;
    logic [SAMPLE_W-1:0] pending_d, pending_q;
    logic                pending_full_d, pending_full_q;
    logic [SAMPLE_W-1:0] active_d, active_q;
    logic                pwm_out_d, pwm_out_q;
    logic                period_start_d, period_start_q;
    logic                underrun_d, underrun_q;
    logic                busy_d, busy_q;

    logic                cnt_clear;
    logic                cnt_run;
    logic [SAMPLE_W-1:0] cnt_next;
    logic                cnt_wrap;
    logic                accept;
    logic                load;
    logic                wrap_load_ok;
    logic [SAMPLE_W-1:0] in_value;

`ifdef PWM_AMPLITUDE_EN
    // (sample * (amplitude + 1)) >> 4 in 12 bits; amplitude 15 is identity.
    function automatic logic [SAMPLE_W-1:0] scale_sample(
        input logic [SAMPLE_W-1:0] s,
        input logic [3:0]          amp
    );
        logic [11:0] prod;
        prod = 12'(s) * 12'({1'b0, amp} + 5'd1);
        return prod[11:4];
    endfunction

    assign in_value = scale_sample(s_if.sample_in, s_if.amplitude);
`else
    assign in_value = s_if.sample_in;
`endif

    // Ready comes from the flag flop only, never from sample_valid.
    assign s_if.sample_ready = ~pending_full_q;
    assign accept            = s_if.sample_valid & ~pending_full_q;

    pwm_period_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .run      (cnt_run),
        .cnt_next (cnt_next),
        .wrap     (cnt_wrap)
    );

    // Control: state transitions, counter commands and wrap-time load.
    always_comb begin
        state_d      = state_q;
        cnt_clear    = 1'b0;
        cnt_run      = 1'b0;
        load         = 1'b0;
        underrun_d   = 1'b0;
        // A STOP with enable back behaves as RUN, including the wrap load.
        wrap_load_ok = (state_q == RUN) || ((state_q == STOP) && enable);

        unique case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (enable && pending_full_q) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_run = 1'b1;
                if (!enable) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_run = 1'b1;
                if (enable) begin
                    state_d = RUN;
                end else if (cnt_wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load decision uses the pre-edge flag, so a sample accepted in the
        // wrap cycle itself still counts as an underrun.
        if (wrap_load_ok && cnt_wrap) begin
            if (pending_full_q) begin
                load = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    // Buffer and active duty; accept and load are mutually exclusive since
    // accept needs the buffer empty and load needs it full.
    always_comb begin
        pending_d      = accept ? in_value : pending_q;
        pending_full_d = accept | (pending_full_q & ~load);
        active_d       = load ? pending_q : active_q;
    end

    // Outputs are computed from next-state values so the registered
    // outputs line up with the counter value of the same cycle.
    always_comb begin
        busy_d         = (state_d != IDLE);
        pwm_out_d      = busy_d && (cnt_next < active_d);
        period_start_d = busy_d && (cnt_next == '0)
                         && ((state_q == IDLE) || cnt_wrap);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
            busy_q         <= busy_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pwm_dac_stage.sv
// Testbench for pwm_dac_stage. Directed steps plus random samples; each
// period is compared against the duty expected from the sample queue.
// Build with PWM_AMPLITUDE_EN defined to include the amplitude checks.
module tb_pwm_dac_stage;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic pwm_out;
    logic period_start;
    logic underrun;
    logic busy;

    int total = 0;
    int bad   = 0;

    // Each entry: {amplitude[3:0], sample[7:0]}
    logic [11:0] txq[$];
    int          expq[$];

    pwm_dac_stage_if sif();

    pwm_dac_stage dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .s_if         (sif),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Duty implied by a sample and gain: (s * (a+1)) / 16; a=15 gives s.
    function automatic int ref_duty(input int s, input int a);
        return (s * (a + 1)) / 16;
    endfunction

    function automatic logic [11:0] mk(input int s, input int a);
        logic [11:0] v;
        v = {a[3:0], s[7:0]};
        return v;
    endfunction

    task automatic offer();
        logic [11:0] v;
        if (sif.sample_valid !== 1'b1 && txq.size() > 0) begin
            v = txq.pop_front();
            sif.sample_in = v[7:0];
`ifdef PWM_AMPLITUDE_EN
            sif.amplitude = v[11:8];
`endif
            sif.sample_valid = 1'b1;
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge. A sample that
    // met valid && ready before the edge is retired and the next offered.
    task automatic step();
        bit acc;
        acc = (sif.sample_valid === 1'b1) && (sif.sample_ready === 1'b1);
        @(posedge clk);
        #1;
        if (acc) begin
            sif.sample_valid = 1'b0;
            offer();
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        enable           = 1'b0;
        sif.sample_valid = 1'b0;
        txq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Enable and start: first edge accepts, second edge enters RUN.
    task automatic start_run();
        enable = 1'b1;
        offer();
        step();
        step();
    endtask

    // Called at the first cycle of a period; walks all 255 cycles.
    task automatic check_period(input string tag, input int duty,
                                input bit exp_under, input int rdy0,
                                input int rdy1, input int inject,
                                input int drop_at);
        int hi = 0, pwm_err = 0, ps_err = 0, ur_err = 0, busy_err = 0;
        for (int i = 0; i < 255; i++) begin
            if (pwm_out === 1'b1) hi++;
            if (pwm_out !== (i < duty)) pwm_err++;
            if (period_start !== (i == 0)) ps_err++;
            if (underrun !== ((i == 0) && exp_under)) ur_err++;
            if (busy !== 1'b1) busy_err++;
            if (i == 0 && rdy0 >= 0) chk1({tag, "_rdy0"}, sif.sample_ready, rdy0[0]);
            if (i == 1 && rdy1 >= 0) chk1({tag, "_rdy1"}, sif.sample_ready, rdy1[0]);
            if (i == inject) begin
                txq.push_back(mk(77, 15));
                offer();
            end
            if (i == drop_at) enable = 1'b0;
            step();
        end
        chkn({tag, "_high_cycles"}, hi, duty);
        chkn({tag, "_pwm_shape_errs"}, pwm_err, 0);
        chkn({tag, "_period_start_errs"}, ps_err, 0);
        chkn({tag, "_underrun_errs"}, ur_err, 0);
        chkn({tag, "_busy_errs"}, busy_err, 0);
    endtask

    initial begin
        int s, a, cnt_busy, cnt_pwm;

        reset            = 1'b1;
        enable           = 1'b0;
        sif.sample_valid = 1'b0;
        sif.sample_in    = '0;
`ifdef PWM_AMPLITUDE_EN
        sif.amplitude    = 4'd15;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_pwm_out", pwm_out, 1'b0);
        chk1("rst_period_start", period_start, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", sif.sample_ready, 1'b1);
        reset = 1'b0;

        // Single sample 64: one period, then an underrun repeat.
        txq.push_back(mk(64, 15));
        enable = 1'b1;
        offer();
        step();
        chk1("t1_ready_after_accept", sif.sample_ready, 1'b0);
        chk1("t1_busy_before_run", busy, 1'b0);
        step();
        check_period("t1_p1", 64, 1'b0, 1, 1, -1, -1);
        check_period("t1_p2", 64, 1'b1, 1, 1, -1, -1);

        // Back-to-back 0, 255, 128 with valid held.
        do_reset();
        txq.push_back(mk(0, 15));
        txq.push_back(mk(255, 15));
        txq.push_back(mk(128, 15));
        start_run();
        check_period("t2_d0", 0, 1'b0, 1, 0, -1, -1);
        check_period("t2_d255", 255, 1'b0, 1, 0, -1, -1);
        check_period("t2_d128", 128, 1'b0, 1, 1, -1, -1);

        // Sample offered in the wrap cycle with the buffer empty.
        check_period("t3_inject", 128, 1'b1, 1, 1, 254, -1);
        check_period("t3_repeat", 128, 1'b1, 0, 0, -1, -1);
        check_period("t3_new", 77, 1'b0, 1, 1, -1, -1);

        // enable dropped mid-period with a sample held in the buffer.
        do_reset();
        txq.push_back(mk(200, 15));
        txq.push_back(mk(99, 15));
        start_run();
        check_period("t4_stop", 200, 1'b0, 1, 0, -1, 100);
        chk1("t4_idle_busy", busy, 1'b0);
        chk1("t4_idle_pwm", pwm_out, 1'b0);
        chk1("t4_idle_ready", sif.sample_ready, 1'b0);
        chk1("t4_idle_period_start", period_start, 1'b0);
        chk1("t4_idle_underrun", underrun, 1'b0);
        cnt_busy = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0 || pwm_out !== 1'b0) cnt_busy++;
        end
        chkn("t4_stays_idle", cnt_busy, 0);
        enable = 1'b1;
        step();
        check_period("t4_reload", 99, 1'b0, 1, 1, -1, -1);

        // Asynchronous reset while pwm_out is high.
        do_reset();
        txq.push_back(mk(150, 15));
        txq.push_back(mk(33, 15));
        start_run();
        for (int i = 0; i < 50; i++) step();
        chk1("t5_pwm_high_at_50", pwm_out, 1'b1);
        chk1("t5_ready_full", sif.sample_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk1("t5_async_pwm", pwm_out, 1'b0);
        chk1("t5_async_busy", busy, 1'b0);
        chk1("t5_async_ready", sif.sample_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk1("t5_ready_after_release", sif.sample_ready, 1'b1);
        chk1("t5_busy_after_release", busy, 1'b0);
        cnt_busy = 0;
        cnt_pwm  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0) cnt_busy++;
            if (pwm_out !== 1'b0) cnt_pwm++;
        end
        chkn("t5_pending_discarded_busy", cnt_busy, 0);
        chkn("t5_pending_discarded_pwm", cnt_pwm, 0);

`ifdef PWM_AMPLITUDE_EN
        // Amplitude scaling at accept time.
        do_reset();
        txq.push_back(mk(200, 7));
        txq.push_back(mk(255, 15));
        start_run();
        check_period("t6_amp7", 100, 1'b0, 1, 0, -1, -1);
        check_period("t6_amp15", 255, 1'b0, 1, 1, -1, -1);
`endif

        // Random samples against the queue-order reference.
        do_reset();
        expq.delete();
        for (int k = 0; k < 6; k++) begin
            s = int'($urandom_range(0, 255));
`ifdef PWM_AMPLITUDE_EN
            a = int'($urandom_range(0, 15));
`else
            a = 15;
`endif
            txq.push_back(mk(s, a));
            expq.push_back(ref_duty(s, a));
        end
        start_run();
        for (int k = 0; k < 6; k++) begin
            check_period($sformatf("rnd%0d", k), expq[k], 1'b0, -1, -1, -1, -1);
        end
        check_period("rnd_tail", expq[5], 1'b1, 1, 1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
